muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Parametrised RV32M/RV64M multiply/divide execution unit. It sits beside the integer ALU and its decoder, and is selected when an R-type op carries funct7 = 0000001. It decodes funct3 into the eight M-extension operations and computes each one iteratively. Operands enter and results leave through valid/ready handshakes, so the pipeline stalls on it as a multi-cycle functional unit.

Parameters:
XLEN, 32, operand and result width; must be 32 or 64.
BITS_PER_CYCLE, 1, quotient/multiplier bits retired per CALC cycle; must be 1, 2 or 4 and divide XLEN exactly.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start_valid  input  1  operation request
start_ready  output  1  unit can accept; start_ready = (state==IDLE) && !flush
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1  input  XLEN  first operand (multiplicand / dividend)
rs2  input  XLEN  second operand (multiplier / divisor)
flush  input  1  synchronous abort of any in-flight operation
result_valid  output  1  result available
result  output  XLEN  registered result
result_ready  input  1  consumer takes result
busy  output  1  high in CALC or DONE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, result_valid=0, result=0, busy=0, all internal accumulators 0. start_ready reads 1 once reset is released and flush is low.
- States: IDLE, CALC, DONE.
- Accept: start_valid && start_ready at a rising edge. Latch funct3, rs1, rs2 and the operand signs, then take absolute values as required by the op:
  - MUL/MULH/DIV/REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- Special cases resolve at accept; the next state is DONE directly, and result_valid rises 1 edge after accept:
  - Divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - Signed overflow (DIV/REM with rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): DIV -> rs1; REM -> 0.
- Normal case: IDLE -> CALC. Counter K = XLEN/BITS_PER_CYCLE, decremented per CALC cycle.
  - Multiply: shift-add on a 2*XLEN product register.
  - Divide: restoring shift-subtract on a quotient/remainder pair.
  - When K reaches 0, CALC -> DONE. result_valid rises exactly K+1 edges after the accept edge. Latency is data-independent; there is no early-out.
- Sign fix-up is applied when entering DONE:
  - Product is negated (2*XLEN-bit) if the operand signs differ (MULHSU counts rs2 as positive).
  - Quotient is negated if the dividend and divisor signs differ.
  - Remainder takes the dividend's sign.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2*XLEN-1:XLEN].
- DONE: result and result_valid are held stable until result_valid && result_ready at an edge. That edge moves DONE -> IDLE and clears result_valid. A new request cannot be accepted on that same edge, because start_ready is 0 in DONE; the earliest accept is the next edge.
- flush high at an edge: any state -> IDLE, result_valid=0, and result is not updated.
  - flush has priority over result_ready and over start_valid; a request presented while flush is high is not accepted.
- rst_n asserted mid-operation: immediate return to reset values, with no partial result visible.
- Inputs rs1/rs2/funct3 are ignored outside the accept edge; changing them during CALC has no effect.
- All arithmetic is modulo 2^XLEN (2^(2*XLEN) for the product). No X is ever driven on result.

Test Plan:
1. XLEN=32, BPC=1: MUL rs1=7, rs2=0xFFFFFFFD -> result 0xFFFFFFEB; result_valid exactly 33 edges after accept; busy high throughout.
2. High-half multiplies:
   - MULH 0x80000000*0x80000000 -> 0x40000000
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
   - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
3. Division:
   - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF
   - DIVU 100/7 -> 14; REMU -> 2
   - Repeat with BPC=4: same results, latency 9 edges.
4. Special cases, each with result_valid 1 edge after accept:
   - DIV 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; DIVU 0/0 -> 0xFFFFFFFF
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0
5. Backpressure: hold result_ready=0 for 5 cycles after result_valid -> result stable, start_ready=0. Release -> IDLE next edge; a back-to-back request is accepted on the following edge.
6. Abort:
   - flush at CALC cycle 10 -> IDLE next edge, no result_valid. A start_valid high in the same cycle as flush is not accepted.
   - rst_n pulsed low mid-CALC -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply, restoring divide,
// BITS_PER_CYCLE bits retired per CALC cycle, valid/ready on both sides.
module muldiv_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  input  logic            result_ready,
  output logic            busy
);

  localparam int K     = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(K + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2:0]          op_q, op_d;
  logic                neg_q, neg_d;
  logic                rneg_q, rneg_d;
  logic [XLEN-1:0]     res_q, res_d;
  logic                rv_q, rv_d;

  logic                rs1_signed, rs2_signed, s1, s2, div_zero, div_ovf;
  logic [XLEN-1:0]     abs1, abs2, fix_res, quo, rem;
  logic [2*XLEN-1:0]   step_acc, prod_fix;

  // Upper half holds the running sum (multiply) or partial remainder (divide);
  // lower half holds the multiplier bits still to consume or the dividend/quotient.
  function automatic logic [2*XLEN-1:0] calc_step(input logic [2*XLEN-1:0] acc,
                                                 input logic [XLEN-1:0]   opnd,
                                                 input logic              is_div);
    logic [2*XLEN-1:0] a;
    logic [XLEN:0]     part;
    logic              ge;
    a = acc;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (is_div) begin
        part = {a[2*XLEN-1:XLEN], a[XLEN-1]};
        ge   = (part >= {1'b0, opnd});
        if (ge) part = part - {1'b0, opnd};
        a = {part[XLEN-1:0], a[XLEN-2:0], ge};
      end else begin
        part = {1'b0, a[2*XLEN-1:XLEN]} + (a[0] ? {1'b0, opnd} : '0);
        a = {part, a[XLEN-1:1]};
      end
    end
    return a;
  endfunction

  always_comb begin
    rs1_signed = 1'b0;
    rs2_signed = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b100, 3'b110: begin rs1_signed = 1'b1; rs2_signed = 1'b1; end
      3'b010:                         rs1_signed = 1'b1;
      default:                        ;
    endcase
    s1       = rs1_signed & rs1[XLEN-1];
    s2       = rs2_signed & rs2[XLEN-1];
    abs1     = s1 ? -rs1 : rs1;
    abs2     = s2 ? -rs2 : rs2;
    div_zero = funct3[2] && (rs2 == '0);
    div_ovf  = funct3[2] && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
  end

  always_comb begin
    step_acc = calc_step(acc_q, opnd_q, op_q[2]);
    prod_fix = neg_q ? -step_acc : step_acc;
    quo      = step_acc[XLEN-1:0];
    rem      = step_acc[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = neg_q ? -quo : quo;
      default:                fix_res = rneg_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    rv_d    = rv_q;
    if (flush) begin
      state_d = IDLE;
      rv_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_valid) begin
          op_d   = funct3;
          neg_d  = s1 ^ s2;
          rneg_d = s1;
          if (funct3[2]) begin
            acc_d  = {{XLEN{1'b0}}, abs1};
            opnd_d = abs2;
          end else begin
            acc_d  = {{XLEN{1'b0}}, abs2};
            opnd_d = abs1;
          end
          if (div_zero || div_ovf) begin
            // Zero divisor takes precedence; the overflow case cannot have rs2 == 0.
            if (div_zero) res_d = funct3[1] ? rs1 : '1;
            else          res_d = funct3[1] ? '0 : rs1;
            rv_d    = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = CNT_W'(K);
            state_d = CALC;
          end
        end
        CALC: begin
          acc_d = step_acc;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            res_d   = fix_res;
            rv_d    = 1'b1;
            state_d = DONE;
          end
        end
        DONE: if (result_ready) begin
          rv_d    = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      rv_q    <= rv_d;
    end
  end

  assign start_ready  = (state_q == IDLE) && !flush;
  assign busy         = (state_q != IDLE);
  assign result_valid = rv_q;
  assign result       = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a BITS_PER_CYCLE=1 and a BITS_PER_CYCLE=4 instance
// driven with identical stimulus, each checked against hand-computed results and latency.
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        flush = 1'b0;
  logic        result_ready = 1'b0;

  logic        sr_a, rv_a, busy_a, sr_b, rv_b, busy_b;
  logic [31:0] res_a, res_b;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u_bpc1 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr_a),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .result_valid(rv_a), .result(res_a), .result_ready(result_ready), .busy(busy_a)
  );

  muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(4)) u_bpc4 (
    .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(sr_b),
    .funct3(funct3), .rs1(rs1), .rs2(rs2), .flush(flush),
    .result_valid(rv_b), .result(res_b), .result_ready(result_ready), .busy(busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a request at a falling edge; returns just after the accept edge.
  task automatic start_op(input string tag, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    funct3 = f; rs1 = a; rs2 = b; start_valid = 1'b1;
    #1 check({tag, " start_ready"}, {62'd0, sr_a, sr_b}, 64'd3);
    @(posedge clk);
    #1 start_valid = 1'b0;
    rs1 = 32'hDEAD_BEEF; rs2 = 32'h0; funct3 = 3'b111;
  endtask

  // Latency counts the accept edge as edge 1.
  task automatic wait_valid(output int l1, output int l4, output bit busy_ok);
    l1 = -1; l4 = -1; busy_ok = 1'b1;
    for (int n = 1; n <= 80 && (l1 < 0 || l4 < 0); n++) begin
      @(negedge clk);
      if (!busy_a) busy_ok = 1'b0;
      if (l1 < 0 && rv_a) l1 = n;
      if (l4 < 0 && rv_b) l4 = n;
      if (l1 < 0 || l4 < 0) @(posedge clk);
    end
  endtask

  task automatic release_res(input string tag);
    @(negedge clk);
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0;
    check({tag, " idle after take"}, {60'd0, rv_a, rv_b, busy_a, busy_b}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int el1, input int el4);
    int l1, l4;
    bit bo;
    start_op(tag, f, a, b);
    wait_valid(l1, l4, bo);
    check({tag, " latency bpc1"}, 64'(l1), 64'(el1));
    check({tag, " latency bpc4"}, 64'(l4), 64'(el4));
    check({tag, " busy"}, {63'd0, bo}, 64'd1);
    check({tag, " result bpc1"}, {32'd0, res_a}, {32'd0, exp});
    check({tag, " result bpc4"}, {32'd0, res_b}, {32'd0, exp});
    release_res(tag);
  endtask

  initial begin
    int l1, l4;
    bit bo, bad;
    logic [31:0] held;

    #12;
    check("reset outputs a", {31'd0, rv_a, busy_a, res_a}, 64'd0);
    check("reset outputs b", {31'd0, rv_b, busy_b, res_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("start_ready after reset", {62'd0, sr_a, sr_b}, 64'd3);

    run_op("mul 7*-3",      MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 9);
    run_op("mul big",       MUL,    32'h1234_5678, 32'd9,        32'hA3D7_0A38, 33, 9);
    run_op("mulh min*min",  MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 9);
    run_op("mulhu ff*ff",   MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 9);
    run_op("mulhsu ff*ff",  MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 9);
    run_op("div -7/2",      DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 9);
    run_op("rem -7/2",      REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 9);
    run_op("div 7/-2",      DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 9);
    run_op("rem 7/-2",      REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33, 9);
    run_op("divu 100/7",    DIVU,   32'd100,       32'd7,         32'd14,        33, 9);
    run_op("remu 100/7",    REMU,   32'd100,       32'd7,         32'd2,         33, 9);
    run_op("div 5/0",       DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1);
    run_op("rem 5/0",       REM,    32'd5,         32'd0,         32'd5,         1, 1);
    run_op("divu 0/0",      DIVU,   32'd0,         32'd0,         32'hFFFF_FFFF, 1, 1);
    run_op("remu 9/0",      REMU,   32'd9,         32'd0,         32'd9,         1, 1);
    run_op("div ovf",       DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1);
    run_op("rem ovf",       REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1);

    // Backpressure, then a request presented on the take edge must wait one edge.
    start_op("bp", MUL, 32'd3, 32'd5);
    wait_valid(l1, l4, bo);
    check("bp latency bpc1", 64'(l1), 64'd33);
    held = res_a;
    check("bp result", {32'd0, held}, 64'd15);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (res_a !== held || res_b !== held || !rv_a || !rv_b || sr_a || sr_b) bad = 1'b1;
    end
    check("bp hold stable", {63'd0, bad}, 64'd0);
    @(negedge clk);
    result_ready = 1'b1; start_valid = 1'b1;
    funct3 = MUL; rs1 = 32'd6; rs2 = 32'd7;
    @(posedge clk);
    #1 result_ready = 1'b0;
    check("bp no accept on take edge", {60'd0, rv_a, rv_b, busy_a, busy_b}, 64'd0);
    check("bp ready after take", {62'd0, sr_a, sr_b}, 64'd3);
    @(posedge clk);
    #1 start_valid = 1'b0;
    check("b2b accepted", {62'd0, busy_a, busy_b}, 64'd3);
    wait_valid(l1, l4, bo);
    check("b2b latency bpc1", 64'(l1), 64'd33);
    check("b2b latency bpc4", 64'(l4), 64'd9);
    check("b2b result", {res_a, res_b}, {32'd42, 32'd42});
    release_res("b2b");

    // Flush around CALC cycle 10 with a competing request.
    start_op("flush", MULHU, 32'hFFFF_FFFF, 32'h2);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("flush pre busy", {63'd0, busy_a}, 64'd1);
    flush = 1'b1; start_valid = 1'b1; funct3 = MUL; rs1 = 32'd2; rs2 = 32'd2;
    #1 check("flush blocks start_ready", {62'd0, sr_a, sr_b}, 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; start_valid = 1'b0;
    check("flush to idle", {60'd0, rv_a, rv_b, busy_a, busy_b}, 64'd0);
    check("flush result kept bpc1", {32'd0, res_a}, 64'd42);
    check("flush result bpc4", {32'd0, res_b}, 64'd1);
    bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rv_a || rv_b || busy_a || busy_b) bad = 1'b1;
    end
    check("flush no late result", {63'd0, bad}, 64'd0);

    // Asynchronous reset mid-CALC.
    start_op("rst", MUL, 32'd11, 32'd13);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async reset a", {31'd0, rv_a, busy_a, res_a}, 64'd0);
    check("async reset b", {31'd0, rv_b, busy_b, res_b}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ready after mid reset", {62'd0, sr_a, sr_b}, 64'd3);
    run_op("post reset mul", MUL, 32'd11, 32'd13, 32'd143, 33, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
